// File: rtl/ram_sp_clr_pkg.sv
// ram_sp_clr_pkg: shared read-during-write codes and clear-sequencer state encoding
package ram_sp_clr_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/ram_sp_clr_if.sv
// ram_sp_clr_if: user port of the single-port RAM (request side is master)
interface ram_sp_clr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] addr;
  logic write_en;
  logic read_en;
  logic dout_valid;
  logic ready;
  modport master (output din, addr, write_en, read_en, wmask, input dout, dout_valid, ready);
  modport slave (input din, addr, write_en, read_en, wmask, output dout, dout_valid, ready);
endinterface

// File: rtl/ram_sp_clr_clear_seq.sv
// ram_sp_clr_clear_seq: post-reset sweep over every address, then a terminal run state
module ram_sp_clr_clear_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] waddr,
  output logic              done
);
  import ram_sp_clr_pkg::*;
  // one extra counter bit keeps the last-address test free of wrap ambiguity
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  state_t state;
  logic [ADDR_W:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt <= '0;
      done <= 1'b0;
    end else if (state == ST_CLEAR) begin
      cnt <= en ? cnt + 1'b1 : cnt;
      if (!en || cnt == LAST) begin
        state <= ST_RUN;
        done <= 1'b1;
      end
    end
  assign wr = state == ST_CLEAR && en;
  assign waddr = cnt[ADDR_W-1:0];
endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port RAM with bit write mask, selectable read-during-write and clear sweep
module ram_sp_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OUT_REG = 0,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  ram_sp_clr_if.slave bus
);
  import ram_sp_clr_pkg::*;
  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] old_word, rd_word, d1, d2;
  logic [ADDR_W-1:0] sweep_addr;
  logic sweep_wr, ready, wr, rd, v1, v2;
  ram_sp_clr_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .en(CLEAR_EN != 0),
    .wr(sweep_wr),
    .waddr(sweep_addr),
    .done(ready)
  );
  assign wr = ready && bus.write_en;
  assign rd = ready && bus.read_en;
  assign old_word = mem[bus.addr];
  // new-data mode forwards the masked merge the write is about to store
  assign rd_word = (RDW_MODE == RDW_NEW && wr) ? (bus.din & ~bus.wmask) | (old_word & bus.wmask) : old_word;
  always_ff @(posedge clk)
    if (sweep_wr) mem[sweep_addr] <= CLEAR_VAL;
    else if (wr)
      for (int i = 0; i < DATA_W; i++)
        if (!bus.wmask[i]) mem[bus.addr][i] <= bus.din[i];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      v1 <= rd;
      v2 <= v1;
      if (rd) d1 <= rd_word;
      if (v1) d2 <= d1;
    end
  assign bus.dout = OUT_REG != 0 ? d2 : d1;
  assign bus.dout_valid = OUT_REG != 0 ? v2 : v1;
  assign bus.ready = ready;
endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: directed vectors over default, pipelined/new-data and small no-clear variants
module tb_ram_sp_clr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  ram_sp_clr_if #(.DATA_W(16), .ADDR_W(8)) ia ();
  ram_sp_clr_if #(.DATA_W(16), .ADDR_W(8)) ib ();
  ram_sp_clr_if #(.DATA_W(8), .ADDR_W(4)) ic ();

  ram_sp_clr #(.DATA_W(16), .ADDR_W(8)) ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  ram_sp_clr #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  ram_sp_clr #(.DATA_W(8), .ADDR_W(4), .CLEAR_EN(0)) uc (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] wmask;
    logic [15:0] exp_dout;
    logic        exp_v;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic drv_a(input logic we, input logic re, input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
    ia.write_en = we; ia.read_en = re; ia.addr = a; ia.din = d; ia.wmask = m;
  endtask

  task automatic drv_b(input logic we, input logic re, input logic [7:0] a, input logic [15:0] d);
    ib.write_en = we; ib.read_en = re; ib.addr = a; ib.din = d; ib.wmask = '0;
  endtask

  task automatic drv_c(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
    ic.write_en = we; ic.read_en = re; ic.addr = a; ic.din = d; ic.wmask = '0;
  endtask

  initial begin
    int spur, early;
    drv_a(0, 0, 8'h00, 16'h0, 16'h0);
    drv_b(0, 0, 8'h00, 16'h0);
    drv_c(0, 0, 4'h0, 8'h0);
    #3;
    chk("rst a dout", ia.dout, 16'h0);
    chk("rst a valid", 16'(ia.dout_valid), 16'd0);
    chk("rst a ready", 16'(ia.ready), 16'd0);
    chk("rst c ready", 16'(ic.ready), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drv_a(1, 1, 8'h40, 16'hFFFF, 16'h0);
    spur = 0;
    early = 0;
    fork
      begin
        for (int n = 1; n <= 256; n++) begin
          @(negedge clk);
          if (ia.dout_valid) spur++;
          if (n < 256 && (ia.ready || ib.ready)) early++;
        end
        chk("sweep a ready", 16'(ia.ready), 16'd1);
        chk("sweep b ready", 16'(ib.ready), 16'd1);
        chk("sweep early ready", 16'(early), 16'd0);
        chk("sweep spurious valid", 16'(spur), 16'd0);
      end
      begin
        @(negedge clk);
        chk("c ready edge1", 16'(ic.ready), 16'd1);
        drv_c(1, 0, 4'hF, 8'hA5);
        @(negedge clk);
        drv_c(1, 0, 4'h0, 8'h3C);
        @(negedge clk);
        drv_c(0, 1, 4'hF, 8'h00);
        @(negedge clk);
        chk("c rd F", 16'(ic.dout), 16'h00A5);
        chk("c rd F valid", 16'(ic.dout_valid), 16'd1);
        drv_c(0, 1, 4'h0, 8'h00);
        @(negedge clk);
        chk("c rd 0", 16'(ic.dout), 16'h003C);
        chk("c rd 0 valid", 16'(ic.dout_valid), 16'd1);
        drv_c(0, 0, 4'h0, 8'h00);
        @(negedge clk);
        chk("c hold", 16'(ic.dout), 16'h003C);
        chk("c idle valid", 16'(ic.dout_valid), 16'd0);
      end
    join
    drv_a(0, 0, 8'h00, 16'h0, 16'h0);

    vq.push_back('{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    vq.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h7F, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    vq.push_back('{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    vq.push_back('{1'b1, 1'b0, 8'h12, 16'hBEEF, 16'h0000, 16'h0000, 1'b0});
    vq.push_back('{1'b1, 1'b0, 8'h12, 16'h1234, 16'hFF00, 16'h0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h12, 16'h0000, 16'h0000, 16'hBE34, 1'b1});
    vq.push_back('{1'b1, 1'b0, 8'h05, 16'h5555, 16'h0000, 16'hBE34, 1'b0});
    vq.push_back('{1'b1, 1'b1, 8'h05, 16'hAAAA, 16'h0000, 16'h5555, 1'b1});
    vq.push_back('{1'b0, 1'b1, 8'h05, 16'h0000, 16'h0000, 16'hAAAA, 1'b1});
    vq.push_back('{1'b1, 1'b0, 8'h20, 16'h1111, 16'hFFFF, 16'hAAAA, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h20, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    vq.push_back('{1'b1, 1'b0, 8'h21, 16'h5AF0, 16'h0F0F, 16'h0000, 1'b0});
    vq.push_back('{1'b0, 1'b1, 8'h21, 16'h0000, 16'h0000, 16'h50F0, 1'b1});
    vq.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h50F0, 1'b0});
    foreach (vq[k]) begin
      drv_a(vq[k].we, vq[k].re, vq[k].addr, vq[k].din, vq[k].wmask);
      @(negedge clk);
      chk($sformatf("vec%0d dout", k), ia.dout, vq[k].exp_dout);
      chk($sformatf("vec%0d valid", k), 16'(ia.dout_valid), 16'(vq[k].exp_v));
    end

    drv_b(1, 0, 8'h01, 16'h0011); @(negedge clk);
    drv_b(1, 0, 8'h02, 16'h0022); @(negedge clk);
    drv_b(1, 0, 8'h03, 16'h0033); @(negedge clk);
    drv_b(1, 0, 8'h05, 16'h5555); @(negedge clk);
    drv_b(0, 1, 8'h01, 16'h0);
    @(negedge clk);
    chk("b pipe N+1 valid", 16'(ib.dout_valid), 16'd0);
    drv_b(0, 1, 8'h02, 16'h0);
    @(negedge clk);
    chk("b pipe 1 dout", ib.dout, 16'h0011);
    chk("b pipe 1 valid", 16'(ib.dout_valid), 16'd1);
    drv_b(0, 1, 8'h03, 16'h0);
    @(negedge clk);
    chk("b pipe 2 dout", ib.dout, 16'h0022);
    chk("b pipe 2 valid", 16'(ib.dout_valid), 16'd1);
    drv_b(0, 0, 8'h00, 16'h0);
    @(negedge clk);
    chk("b pipe 3 dout", ib.dout, 16'h0033);
    chk("b pipe 3 valid", 16'(ib.dout_valid), 16'd1);
    @(negedge clk);
    chk("b pipe end dout", ib.dout, 16'h0033);
    chk("b pipe end valid", 16'(ib.dout_valid), 16'd0);
    drv_b(1, 1, 8'h05, 16'hAAAA);
    @(negedge clk);
    drv_b(0, 0, 8'h00, 16'h0);
    chk("b rdw N+1 valid", 16'(ib.dout_valid), 16'd0);
    @(negedge clk);
    chk("b rdw new dout", ib.dout, 16'hAAAA);
    chk("b rdw valid", 16'(ib.dout_valid), 16'd1);

    #2 rst_n = 1'b0;
    #1;
    chk("async rst a dout", ia.dout, 16'h0);
    chk("async rst a ready", 16'(ia.ready), 16'd0);
    chk("async rst b dout", ib.dout, 16'h0);
    chk("async rst c dout", 16'(ic.dout), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(1, 1, 8'h12, 16'hFFFF, 16'h0);
    spur = 0;
    early = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ia.dout_valid) spur++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (ia.dout_valid) spur++;
      if (n < 256 && ia.ready) early++;
    end
    drv_a(0, 0, 8'h00, 16'h0, 16'h0);
    chk("resweep ready", 16'(ia.ready), 16'd1);
    chk("resweep early ready", 16'(early), 16'd0);
    chk("resweep spurious valid", 16'(spur), 16'd0);
    drv_a(0, 1, 8'h12, 16'h0, 16'h0);
    @(negedge clk);
    chk("resweep rd 12", ia.dout, 16'h0);
    chk("resweep rd 12 valid", 16'(ia.dout_valid), 16'd1);
    drv_a(0, 1, 8'h05, 16'h0, 16'h0);
    @(negedge clk);
    chk("resweep rd 05", ia.dout, 16'h0);
    drv_a(0, 0, 8'h00, 16'h0, 16'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
